// File: rtl/stream_demux_1x2_pkg.sv
// rtl/stream_demux_1x2_pkg.sv - shared constants and helpers for the 1x2 stream router
package demux_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 4;

  localparam logic PORT_Y0 = 1'b0;
  localparam logic PORT_Y1 = 1'b1;

  // Pointer width for a power-of-2 depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_demux_1x2_if.sv
// rtl/stream_demux_1x2_if.sv - handshake bundle between the router and its producer/consumers
interface stream_demux_1x2_if #(
  parameter int DATA_W = demux_pkg::DATA_W_DEF
);

  logic              i_valid;
  logic              i_ready;
  logic [DATA_W-1:0] i_data;
  logic              s;
  logic              y0_valid;
  logic              y0_ready;
  logic [DATA_W-1:0] y0_data;
  logic              y1_valid;
  logic              y1_ready;
  logic [DATA_W-1:0] y1_data;
  logic              y_sel;

  modport master (
    output i_valid, i_data, s, y0_ready, y1_ready,
    input  i_ready, y0_valid, y0_data, y1_valid, y1_data, y_sel
  );

  modport slave (
    input  i_valid, i_data, s, y0_ready, y1_ready,
    output i_ready, y0_valid, y0_data, y1_valid, y1_data, y_sel
  );

endinterface

// File: rtl/stream_demux_1x2_fifo.sv
// rtl/stream_demux_1x2_fifo.sv - synchronous FIFO used as a per-output buffer of the router
module demux_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [DATA_W-1:0] head
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Empty FIFO presents zero so the output data is clean during and after reset.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_demux_1x2.sv
// rtl/stream_demux_1x2.sv - registered 1-to-2 stream router with a buffer FIFO per output
// Build option: DEMUX_RR_EN selects round-robin targeting instead of the s input.
module stream_demux_1x2
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  stream_demux_1x2_if.slave  bus
);

  logic target;
  logic full0;
  logic full1;
  logic empty0;
  logic empty1;
  logic accept;

`ifdef DEMUX_RR_EN
  logic rr_ptr;

  // Pointer advances only on an accepted word; a full target stalls rather than skipping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= PORT_Y0;
    end else if (accept) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  assign target = rr_ptr;
`else
  assign target = bus.s;
`endif

  assign bus.y_sel   = target;
  assign bus.i_ready = (target == PORT_Y0) ? ~full0 : ~full1;
  assign accept      = bus.i_valid & bus.i_ready;

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (accept & (target == PORT_Y0)),
    .push_data (bus.i_data),
    .pop       (bus.y0_ready),
    .full      (full0),
    .empty     (empty0),
    .head      (bus.y0_data)
  );

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (accept & (target == PORT_Y1)),
    .push_data (bus.i_data),
    .pop       (bus.y1_ready),
    .full      (full1),
    .empty     (empty1),
    .head      (bus.y1_data)
  );

  assign bus.y0_valid = ~empty0;
  assign bus.y1_valid = ~empty1;

endmodule
